// File: rtl/alu_seq_rv32i.sv
// rtl/alu_seq_rv32i.sv - multi-cycle RV32I ALU with serial shifter and valid/ready handshakes
module alu_seq_rv32i #(
  parameter int N       = 32,
  parameter int SHAMT_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] op1,
  input  logic [N-1:0] op2,
  input  logic [2:0]   op_code,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] dout,
  output logic         zero_flag,
  output logic         sign_out,
  output logic         cry_out
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_n;
  logic [N-1:0]       acc, acc_n, acc_sh, dout_n;
  logic [SHAMT_W-1:0] cnt, cnt_n, shamt;
  logic [2:0]         op, op_n;
  logic [N:0]         sum, diff;
  logic               sh_bit, cry_n, load;

  assign shamt = op2[SHAMT_W-1:0];
  assign sum   = {1'b0, op1} + {1'b0, op2};
  assign diff  = {1'b0, op1} + {1'b0, ~op2} + {{N{1'b0}}, 1'b1};

  // One-bit shift step; sh_bit is the bit leaving the accumulator this edge.
  always_comb begin
    acc_sh = {1'b0, acc[N-1:1]};
    sh_bit = acc[0];
    case (op)
      OP_SLL: begin
        acc_sh = {acc[N-2:0], 1'b0};
        sh_bit = acc[N-1];
      end
      OP_SRA: acc_sh = {acc[N-1], acc[N-1:1]};
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    op_n    = op;
    dout_n  = dout;
    cry_n   = cry_out;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_n = op_code;
          load = 1'b1;
          cry_n = 1'b0;
          case (op_code)
            OP_ADD: begin
              dout_n = sum[N-1:0];
              cry_n  = sum[N];
            end
            OP_SUB: begin
              dout_n = diff[N-1:0];
              cry_n  = diff[N];
            end
            OP_AND: dout_n = op1 & op2;
            OP_OR:  dout_n = op1 | op2;
            OP_XOR: dout_n = op1 ^ op2;
            default: begin
              if (shamt == '0) begin
                dout_n = op1;
              end else begin
                load  = 1'b0;
                acc_n = op1;
                cnt_n = shamt;
              end
            end
          endcase
          state_n = load ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        acc_n = acc_sh;
        cnt_n = cnt - SHAMT_W'(1);
        if (cnt == SHAMT_W'(1)) begin
          load    = 1'b1;
          dout_n  = acc_sh;
          cry_n   = sh_bit;
          state_n = DONE;
        end
      end
      DONE: begin
        if (out_valid && out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      op        <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      dout      <= '0;
      zero_flag <= 1'b0;
      sign_out  <= 1'b0;
      cry_out   <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      op        <= op_n;
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
      if (load) begin
        dout      <= dout_n;
        zero_flag <= (dout_n == '0);
        sign_out  <= dout_n[N-1];
        cry_out   <= cry_n;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_rv32i.sv
// tb/tb_alu_seq_rv32i.sv - directed self-checking bench for alu_seq_rv32i
module tb_alu_seq_rv32i;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] op1, op2, dout;
  logic [2:0]  op_code;
  logic        zero_flag, sign_out, cry_out;
  int          n_checks = 0;
  int          n_fail = 0;

  alu_seq_rv32i dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .op_code(op_code), .out_valid(out_valid),
    .out_ready(out_ready), .dout(dout), .zero_flag(zero_flag),
    .sign_out(sign_out), .cry_out(cry_out)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [2:0] oc, input logic [31:0] a, input logic [31:0] b,
                      output int lat);
    int w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    in_valid = 1'b1; op_code = oc; op1 = a; op2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op1 = '0; op2 = '0; op_code = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid, dout, zero_flag, sign_out, cry_out} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0",
               {in_ready, out_valid, dout, zero_flag, sign_out, cry_out});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_add();
    int lat;
    send(3'b000, 32'hffffffff, 32'h00000001, lat);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d expected 1", lat); end
    n_checks++;
    if ({dout, zero_flag, sign_out, cry_out} !== {32'h0, 3'b101}) begin
      n_fail++;
      $display("FAIL add_result: got %h expected %h", {dout, zero_flag, sign_out, cry_out},
               {32'h0, 3'b101});
    end
    consume();
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL add_after_handshake: got %b expected 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_shifts();
    int lat;
    logic [2:0]  oc [5]  = '{3'b100, 3'b101, 3'b101, 3'b110, 3'b110};
    logic [31:0] a  [5]  = '{32'hffffffff, 32'h1, 32'h1, 32'h80000000, 32'hf0000000};
    logic [31:0] b  [5]  = '{32'h1, 32'h2, 32'h1, 32'hffff001f, 32'h4};
    int          el [5]  = '{2, 3, 2, 32, 5};
    logic [34:0] ex [5]  = '{{32'hfffffffe, 3'b011}, {32'h0, 3'b100}, {32'h0, 3'b101},
                             {32'hffffffff, 3'b010}, {32'hff000000, 3'b010}};
    for (int i = 0; i < 5; i++) begin
      send(oc[i], a[i], b[i], lat);
      n_checks++;
      if (lat !== el[i]) begin
        n_fail++;
        $display("FAIL shift%0d_latency: got %0d expected %0d", i, lat, el[i]);
      end
      n_checks++;
      if ({dout, zero_flag, sign_out, cry_out} !== ex[i]) begin
        n_fail++;
        $display("FAIL shift%0d_result: got %h expected %h", i,
                 {dout, zero_flag, sign_out, cry_out}, ex[i]);
      end
      consume();
    end
  endtask

  task automatic test_logic();
    int lat;
    logic [2:0]  oc [5] = '{3'b010, 3'b011, 3'b111, 3'b110, 3'b001};
    logic [31:0] a  [5] = '{32'hf0f0f0f0, 32'hf0f0f0f0, 32'hf0f0f0f0, 32'h80000001, 32'h7};
    logic [31:0] b  [5] = '{32'hff00ff00, 32'hff00ff00, 32'hff00ff00, 32'h00000020, 32'h5};
    logic [34:0] ex [5] = '{{32'hf000f000, 3'b010}, {32'hfff0fff0, 3'b010},
                            {32'h0ff00ff0, 3'b000}, {32'h80000001, 3'b010}, {32'h2, 3'b001}};
    for (int i = 0; i < 5; i++) begin
      send(oc[i], a[i], b[i], lat);
      n_checks++;
      if (lat !== 1 || {dout, zero_flag, sign_out, cry_out} !== ex[i]) begin
        n_fail++;
        $display("FAIL logic%0d: got lat %0d val %h expected lat 1 val %h", i, lat,
                 {dout, zero_flag, sign_out, cry_out}, ex[i]);
      end
      consume();
    end
  endtask

  task automatic test_sub_hold();
    int lat;
    send(3'b001, 32'h5, 32'h7, lat);
    n_checks++;
    if (lat !== 1 || {dout, zero_flag, sign_out, cry_out} !== {32'hfffffffe, 3'b010}) begin
      n_fail++;
      $display("FAIL sub_result: got lat %0d val %h expected lat 1 val %h", lat,
               {dout, zero_flag, sign_out, cry_out}, {32'hfffffffe, 3'b010});
    end
    in_valid = 1'b1; op_code = 3'b000; op1 = 32'h1; op2 = 32'h1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({in_ready, out_valid, dout, zero_flag, sign_out, cry_out} !==
          {2'b01, 32'hfffffffe, 3'b010}) begin
        n_fail++;
        $display("FAIL sub_hold%0d: got %h expected %h", i,
                 {in_ready, out_valid, dout, zero_flag, sign_out, cry_out},
                 {2'b01, 32'hfffffffe, 3'b010});
      end
    end
    in_valid = 1'b0;
    consume();
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL sub_release: got %b expected 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    in_valid = 1'b1; op_code = 3'b101; op1 = 32'hffffffff; op2 = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid, dout} !== 34'd0) begin
      n_fail++;
      $display("FAIL abort_reset: got %h expected 0", {in_ready, out_valid, dout});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_in_ready: got %b expected 1", in_ready);
    end
    send(3'b000, 32'h2, 32'h3, lat);
    n_checks++;
    if (lat !== 1 || {dout, zero_flag, sign_out, cry_out} !== {32'h5, 3'b000}) begin
      n_fail++;
      $display("FAIL abort_add: got lat %0d val %h expected lat 1 val %h", lat,
               {dout, zero_flag, sign_out, cry_out}, {32'h5, 3'b000});
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_add();
    test_shifts();
    test_logic();
    test_sub_hold();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
